// File: rtl/pass_manager.sv
// Four-digit BCD password manager: sets a new password or checks an unlock attempt.
// Optional lockout after three failed unlocks when PASS_LOCKOUT_EN is defined.
module pass_manager #(
  parameter logic [15:0] DEFAULT_PASS = 16'h1234,
  parameter logic [31:0] LOCK_CYCLES  = 32'd250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] f_pass,
  input  logic [3:0] digit,
  input  logic       key_ok,
  input  logic       key_clr,
  output logic [1:0] flag_pass,
  output logic [2:0] n_digits,
  output logic       err,
  output logic       lockout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_NEW    = 2'd1;
  localparam logic [1:0] S_UNLOCK = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  logic [1:0]  state, state_n;
  logic [11:0] entry_buf, buf_n;
  logic [2:0]  cnt_n;
  logic [15:0] pass_q, pass_n;
  logic [1:0]  fail_cnt, fail_n;
  logic [1:0]  flag_n;
  logic        err_n;
  logic        ok_prev, clr_prev;
  logic        ok_edge, clr_edge, accept;
  logic [15:0] code;

  assign ok_edge  = key_ok & ~ok_prev;
  assign clr_edge = key_clr & ~clr_prev;
  // A clear edge in the same cycle drops the digit.
  assign accept   = ok_edge & ~clr_edge & (digit <= 4'd9);
  assign code     = {entry_buf, digit};

`ifdef PASS_LOCKOUT_EN
  logic [31:0] timer, timer_n;
`endif

  always_comb begin
    state_n = state;
    buf_n   = entry_buf;
    cnt_n   = n_digits;
    pass_n  = pass_q;
    fail_n  = fail_cnt;
    err_n   = 1'b0;
`ifdef PASS_LOCKOUT_EN
    timer_n = timer;
`endif
    case (state)
      S_IDLE: begin
        if (f_pass == 2'b01) begin
          state_n = S_NEW;
          buf_n   = '0;
          cnt_n   = '0;
        end else if (f_pass == 2'b10) begin
          state_n = S_UNLOCK;
          buf_n   = '0;
          cnt_n   = '0;
        end
      end
      S_NEW: begin
        if (f_pass == 2'b00) begin
          state_n = S_IDLE;
          buf_n   = '0;
          cnt_n   = '0;
        end else if (clr_edge) begin
          buf_n = '0;
          cnt_n = '0;
        end else if (accept) begin
          if (n_digits == 3'd3) begin
            pass_n  = code;
            state_n = S_IDLE;
            buf_n   = '0;
            cnt_n   = '0;
          end else begin
            buf_n = {entry_buf[7:0], digit};
            cnt_n = n_digits + 3'd1;
          end
        end
      end
      S_UNLOCK: begin
        if (clr_edge) begin
          buf_n = '0;
          cnt_n = '0;
        end else if (accept) begin
          if (n_digits == 3'd3) begin
            buf_n = '0;
            cnt_n = '0;
            if (code == pass_q) begin
              state_n = S_IDLE;
              fail_n  = '0;
            end else begin
              err_n  = 1'b1;
              fail_n = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
`ifdef PASS_LOCKOUT_EN
              if (fail_cnt == 2'd2) begin
                state_n = S_LOCK;
                timer_n = '0;
              end
`endif
            end
          end else begin
            buf_n = {entry_buf[7:0], digit};
            cnt_n = n_digits + 3'd1;
          end
        end
      end
      default: begin
`ifdef PASS_LOCKOUT_EN
        if (timer == LOCK_CYCLES - 32'd1) begin
          state_n = S_UNLOCK;
          timer_n = '0;
          fail_n  = '0;
        end else begin
          timer_n = timer + 32'd1;
        end
`else
        state_n = S_IDLE;
`endif
      end
    endcase
  end

  always_comb begin
    case (state_n)
      S_NEW:           flag_n = 2'b01;
      S_UNLOCK, S_LOCK: flag_n = 2'b10;
      default:         flag_n = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      entry_buf <= '0;
      n_digits  <= '0;
      pass_q    <= DEFAULT_PASS;
      fail_cnt  <= '0;
      flag_pass <= 2'b00;
      err       <= 1'b0;
      ok_prev   <= 1'b0;
      clr_prev  <= 1'b0;
    end else begin
      state     <= state_n;
      entry_buf <= buf_n;
      n_digits  <= cnt_n;
      pass_q    <= pass_n;
      fail_cnt  <= fail_n;
      flag_pass <= flag_n;
      err       <= err_n;
      ok_prev   <= key_ok;
      clr_prev  <= key_clr;
    end
  end

`ifdef PASS_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      lockout <= 1'b0;
    end else begin
      timer   <= timer_n;
      lockout <= (state_n == S_LOCK);
    end
  end
`else
  // Without lockout the fail count and timer length have no observable effect.
  logic unused_cfg;
  assign unused_cfg = ^{LOCK_CYCLES, fail_cnt};
  assign lockout    = 1'b0;
`endif

endmodule
